elevador_cabine: RTL and testbench

- Car/shaft model answering the elevator controller's motor commands.
- Consumes motor_up / motor_down, moves the car between floors with a fixed travel time, and runs door open/close timing.
- Reports floor position back to the controller.
- Closes the loop for system-level simulation; the floor-sensor path is synthesizable for the FPGA demo board.

---
 rtl/elevador_cabine_if.sv | 34 +++
 rtl/elevador_cabine.sv | 164 ++++++++++++++++
 tb/tb_elevador_cabine.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/elevador_cabine_if.sv
// Motor command / car status bundle between the elevator controller
// (master) and the car/shaft model (slave).
interface elevador_cabine_if;
    logic       motor_up;
    logic       motor_down;
    logic [2:0] andar_sensor;
    logic       alinhado;
    logic       chegou;
    logic       em_movimento;
    logic       porta_aberta;
    logic       falha;

    modport master (
        output motor_up,
        output motor_down,
        input  andar_sensor,
        input  alinhado,
        input  chegou,
        input  em_movimento,
        input  porta_aberta,
        input  falha
    );

    modport slave (
        input  motor_up,
        input  motor_down,
        output andar_sensor,
        output alinhado,
        output chegou,
        output em_movimento,
        output porta_aberta,
        output falha
    );
endinterface

// File: rtl/elevador_cabine.sv
// Car/shaft model: follows motor_up/motor_down one whole floor at a time,
// runs the door timing after each stop and reports the floor position.
// Optional macro LIMIT_GUARD_EN: a motor command toward a shaft limit
// (up at the top floor, down at floor 0) latches a fault instead of
// being ignored.
module elevador_cabine #(
    parameter int N_ANDARES    = 5,
    parameter int CICLOS_ANDAR = 4,
    parameter int CICLOS_PORTA = 3
) (
    input logic              clk,
    input logic              reset,
    elevador_cabine_if.slave bus
);
    localparam int PASSO_W = $clog2(CICLOS_ANDAR);
    localparam int PORTA_W = $clog2(CICLOS_PORTA + 1);
    localparam logic [2:0]         ANDAR_TOPO = 3'(N_ANDARES - 1);
    localparam logic [PASSO_W-1:0] PASSO_FIM  = PASSO_W'(CICLOS_ANDAR - 1);
    localparam logic [PORTA_W-1:0] PORTA_FIM  = PORTA_W'(CICLOS_PORTA - 1);

`ifdef LIMIT_GUARD_EN
    localparam bit LIMITE_FALHA = 1'b1;
`else
    localparam bit LIMITE_FALHA = 1'b0;
`endif

    typedef enum logic [2:0] {PARADO, SUBINDO, DESCENDO, PORTA, FALHA} estado_t;

    estado_t              estado_q, estado_d;
    logic [PASSO_W-1:0]   passo_q, passo_d;
    logic [PORTA_W-1:0]   porta_cnt_q, porta_cnt_d;
    logic [2:0]           andar_q, andar_d;
    logic                 alinhado_q, alinhado_d;
    logic                 chegou_q, chegou_d;
    logic                 em_movimento_q, porta_aberta_q, falha_q;
    logic                 ambos;
    logic [2:0]           andar_acima, andar_abaixo;

    assign ambos        = bus.motor_up & bus.motor_down;
    assign andar_acima  = andar_q + 3'd1;
    assign andar_abaixo = andar_q - 3'd1;

    // Next state and next register values for every output.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        estado_d    = estado_q;
        passo_d     = passo_q;
        porta_cnt_d = porta_cnt_q;
        andar_d     = andar_q;
        alinhado_d  = alinhado_q;
        chegou_d    = 1'b0;

        case (estado_q)
            PARADO: begin
                if (ambos) begin
                    estado_d = FALHA;
                end else if (bus.motor_up && andar_q < ANDAR_TOPO) begin
                    estado_d   = SUBINDO;
                    passo_d    = '0;
                    alinhado_d = 1'b0;
                end else if (bus.motor_down && andar_q != 3'd0) begin
                    estado_d   = DESCENDO;
                    passo_d    = '0;
                    alinhado_d = 1'b0;
                end else if ((bus.motor_up || bus.motor_down) && LIMITE_FALHA) begin
                    estado_d = FALHA;
                end
            end

            SUBINDO: begin
                if (ambos) begin
                    estado_d = FALHA;
                end else if (passo_q == PASSO_FIM) begin
                    // Floor crossing: the only point where the motor is sampled.
                    andar_d    = andar_acima;
                    passo_d    = '0;
                    chegou_d   = 1'b1;
                    alinhado_d = 1'b1;
                    if (bus.motor_up && andar_acima < ANDAR_TOPO) begin
                        estado_d = SUBINDO;
                    end else if (bus.motor_up && LIMITE_FALHA) begin
                        estado_d = FALHA;
                    end else begin
                        estado_d    = PORTA;
                        porta_cnt_d = '0;
                    end
                end else begin
                    passo_d    = passo_q + 1'b1;
                    alinhado_d = 1'b0;
                end
            end

            DESCENDO: begin
                if (ambos) begin
                    estado_d = FALHA;
                end else if (passo_q == PASSO_FIM) begin
                    andar_d    = andar_abaixo;
                    passo_d    = '0;
                    chegou_d   = 1'b1;
                    alinhado_d = 1'b1;
                    if (bus.motor_down && andar_abaixo != 3'd0) begin
                        estado_d = DESCENDO;
                    end else if (bus.motor_down && LIMITE_FALHA) begin
                        estado_d = FALHA;
                    end else begin
                        estado_d    = PORTA;
                        porta_cnt_d = '0;
                    end
                end else begin
                    passo_d    = passo_q + 1'b1;
                    alinhado_d = 1'b0;
                end
            end

            PORTA: begin
                alinhado_d = 1'b1;
                if (ambos) begin
                    estado_d = FALHA;
                end else if (porta_cnt_q == PORTA_FIM) begin
                    estado_d = PARADO;
                end else begin
                    porta_cnt_d = porta_cnt_q + 1'b1;
                end
            end

            FALHA: estado_d = FALHA;

            default: estado_d = FALHA;
        endcase
    end

    // State, counters and registered outputs; reset drops the car to floor 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q       <= PARADO;
            passo_q        <= '0;
            porta_cnt_q    <= '0;
            andar_q        <= 3'd0;
            alinhado_q     <= 1'b1;
            chegou_q       <= 1'b0;
            em_movimento_q <= 1'b0;
            porta_aberta_q <= 1'b0;
            falha_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register sees the pre-edge values.
            estado_q       <= estado_d;
            passo_q        <= passo_d;
            porta_cnt_q    <= porta_cnt_d;
            andar_q        <= andar_d;
            alinhado_q     <= alinhado_d;
            chegou_q       <= chegou_d;
            em_movimento_q <= (estado_d == SUBINDO) || (estado_d == DESCENDO);
            porta_aberta_q <= (estado_d == PORTA);
            falha_q        <= (estado_d == FALHA);
        end
    end

    assign bus.andar_sensor = andar_q;
    assign bus.alinhado     = alinhado_q;
    assign bus.chegou       = chegou_q;
    assign bus.em_movimento = em_movimento_q;
    assign bus.porta_aberta = porta_aberta_q;
    assign bus.falha        = falha_q;
endmodule

// File: tb/tb_elevador_cabine.sv
// Scoreboard bench for elevador_cabine: directed scenarios followed by
// randomized motor commands, compared cycle by cycle against a
// timestamp-based car model.
module tb_elevador_cabine;
    localparam int N  = 5;
    localparam int CA = 4;
    localparam int CP = 3;

`ifdef LIMIT_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    elevador_cabine_if bus ();

    elevador_cabine #(
        .N_ANDARES   (N),
        .CICLOS_ANDAR(CA),
        .CICLOS_PORTA(CP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [2:0] andar;
        logic       alinhado;
        logic       chegou;
        logic       movendo;
        logic       porta;
        logic       falha;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   ciclo  = 0;

    // Reference model: car position plus absolute cycle stamps of the next
    // floor arrival and of the door closing.
    int m_now, m_floor, m_dir, m_arrive, m_close;
    bit m_door, m_fault, m_al, m_ch;

    function automatic obs_t observe();
        obs_t o;
        o.andar    = bus.andar_sensor;
        o.alinhado = bus.alinhado;
        o.chegou   = bus.chegou;
        o.movendo  = bus.em_movimento;
        o.porta    = bus.porta_aberta;
        o.falha    = bus.falha;
        return o;
    endfunction

    function automatic obs_t expected();
        obs_t o;
        o.andar    = 3'(m_floor);
        o.alinhado = m_al;
        o.chegou   = m_ch;
        o.movendo  = (m_dir != 0);
        o.porta    = m_door;
        o.falha    = m_fault;
        return o;
    endfunction

    task automatic check(input string nome, input obs_t a, input obs_t e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s cycle %0d: got andar=%0d al=%b ch=%b mov=%b porta=%b falha=%b, expected andar=%0d al=%b ch=%b mov=%b porta=%b falha=%b",
                      nome, ciclo, a.andar, a.alinhado, a.chegou, a.movendo, a.porta, a.falha,
                      e.andar, e.alinhado, e.chegou, e.movendo, e.porta, e.falha);
    endtask

    task automatic model_reset();
        m_now = 0; m_floor = 0; m_dir = 0; m_arrive = 0; m_close = 0;
        m_door = 1'b0; m_fault = 1'b0; m_al = 1'b1; m_ch = 1'b0;
    endtask

    // One clock edge of the model with the motor levels the car samples there.
    task automatic model_step(input bit u, input bit d);
        bit want;
        m_now++;
        m_ch = 1'b0;
        if (m_fault) return;
        if (u && d) begin
            m_fault = 1'b1; m_dir = 0; m_door = 1'b0;
            return;
        end
        if (m_dir != 0) begin
            if (m_now == m_arrive) begin
                want    = (m_dir > 0) ? u : d;
                m_floor = m_floor + m_dir;
                m_ch    = 1'b1;
                m_al    = 1'b1;
                if (want && (m_floor + m_dir) >= 0 && (m_floor + m_dir) <= N - 1) begin
                    m_arrive = m_now + CA;
                end else if (want && GUARD) begin
                    m_fault = 1'b1; m_dir = 0;
                end else begin
                    m_dir = 0; m_door = 1'b1; m_close = m_now + CP;
                end
            end else begin
                m_al = 1'b0;
            end
        end else if (m_door) begin
            if (m_now == m_close) m_door = 1'b0;
        end else begin
            if (u && m_floor < N - 1) begin
                m_dir = 1; m_arrive = m_now + CA; m_al = 1'b0;
            end else if (d && m_floor > 0) begin
                m_dir = -1; m_arrive = m_now + CA; m_al = 1'b0;
            end else if ((u || d) && GUARD) begin
                m_fault = 1'b1;
            end
        end
    endtask

    // Drive one cycle of motor commands; the expected post-edge outputs go
    // to the scoreboard. Called and returns just after a falling edge.
    task automatic tick(input bit u, input bit d);
        bus.motor_up   = u;
        bus.motor_down = d;
        model_step(u, d);
        exp_q.push_back(expected());
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic hold(input bit u, input bit d, input int n);
        for (int i = 0; i < n; i++) tick(u, d);
    endtask

    task automatic apply_reset();
        obs_t r;
        r = '{andar: 3'd0, alinhado: 1'b1, chegou: 1'b0, movendo: 1'b0, porta: 1'b0, falha: 1'b0};
        bus.motor_up   = 1'b0;
        bus.motor_down = 1'b0;
        reset = 1'b0;
        #1;
        check("reset", observe(), r);
        model_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: every falling edge compares the outputs with the oldest
    // pending expectation.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            ciclo++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("saidas", observe(), e);
            end
        end
    end

    initial begin
        int r, len;
        bit u, d;
        bus.motor_up   = 1'b0;
        bus.motor_down = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        apply_reset();

        // Idle after reset: nothing moves.
        idle(20);
        // Up from floor 0 to the top floor, then the door cycle.
        hold(1'b1, 1'b0, 16);
        idle(6);
        // One-cycle down command still completes a whole floor.
        tick(1'b0, 1'b1);
        idle(4);
        // Down pulse while the door is open is ignored.
        tick(1'b0, 1'b1);
        idle(5);
        // Down held from floor 3 to floor 0.
        hold(1'b0, 1'b1, 12);
        idle(6);
        // Both motors mid-travel at passo 2: sticky fault until reset.
        tick(1'b1, 1'b0);
        idle(2);
        tick(1'b1, 1'b1);
        idle(5);
        apply_reset();
        // Down command at floor 0.
        hold(1'b0, 1'b1, 5);
        idle(3);

        // Randomized command segments with occasional resets.
        for (int s = 0; s < 120; s++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                apply_reset();
            end else begin
                r   = $urandom_range(0, 99);
                u   = (r < 44) || (r < 4);
                d   = (r >= 44 && r < 84) || (r < 4);
                len = $urandom_range(1, 12);
                hold(u, d, len);
            end
        end
        idle(8);

        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
